// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared constants and types for the I2C core: data width,
//                transmit FIFO geometry and bus mode encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    localparam int I2C_DATA_W    = 8;
    localparam int TX_FIFO_DEPTH = 16;
    localparam int TX_FIFO_AF    = 12;

    localparam int SYS_CLK_HZ    = 50_000_000;

    // Bus speed selection consumed by the clock generator
    typedef enum logic [1:0] {
        MODE_STANDARD  = 2'd0,   // 100 kHz
        MODE_FAST      = 2'd1,   // 400 kHz
        MODE_FAST_PLUS = 2'd2    // 1 MHz
    } i2c_mode_e;

    // System clocks per quarter SCL period for a given mode
    function automatic int scl_quarter_div(input i2c_mode_e mode);
        int rate_hz;
        case (mode)
            MODE_FAST:      rate_hz = 400_000;
            MODE_FAST_PLUS: rate_hz = 1_000_000;
            default:        rate_hz = 100_000;
        endcase
        return SYS_CLK_HZ / (4 * rate_hz);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_fifo_mem
//  Description : DEPTH x DATA_W simple dual-port memory, synchronous write,
//                registered read output. Array itself is not reset so it can
//                map to block RAM; only the output register is cleared.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_fifo_mem
    import i2c_pkg::*;
#(
    parameter int DATA_W = I2C_DATA_W,
    parameter int DEPTH  = TX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_byte,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_byte
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store a byte on each enabled edge
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_byte;
        end
    end

    // Read port: output register updates only on an enabled read, else holds
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_byte <= '0;
        end else if (rd_en) begin
            rd_byte <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_tx_fifo
//  Description : Transmit byte FIFO between the host write port and the I2C
//                master. Explicit occupancy counter, registered flags derived
//                from the next count, sticky overflow/underflow errors.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_tx_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_W   = I2C_DATA_W,
    parameter int DEPTH    = TX_FIFO_DEPTH,
    parameter int AF_LEVEL = TX_FIFO_AF,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_data,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              almost_full,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              empty_tx,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          wr_accept;
    logic          rd_accept;

    // Acceptance uses the registered flags: a full FIFO still drains, an
    // empty FIFO still fills, and nothing bypasses the storage.
    assign wr_accept = wr_data && !full;
    assign rd_accept = read && !empty_tx;

    // Next occupancy: simultaneous accepted write and read cancel out
    always_comb begin
        count_next = count;
        if (wr_accept && !rd_accept) begin
            count_next = count + 1'b1;
        end else if (rd_accept && !wr_accept) begin
            count_next = count - 1'b1;
        end
    end

    // Pointers, counter and flags; flags track count_next so they line up
    // with count in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            empty_tx    <= 1'b1;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            full        <= (count_next == CW'(DEPTH));
            almost_full <= (count_next >= CW'(AF_LEVEL));
            empty_tx    <= (count_next == '0);
        end
    end

    // One-cycle valid pulse per accepted read, aligned with data_out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_data && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (read && empty_tx) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    i2c_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_byte (data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr),
        .rd_byte (data_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_i2c_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_tx_fifo
//  Description : Self-checking bench for i2c_tx_fifo against a queue-based
//                reference model, directed scenarios plus random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_tx_fifo;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_data = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              read = 1'b0;
    logic              clr_err = 1'b0;
    logic              full;
    logic              almost_full;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              empty_tx;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_valid = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_udf = 1'b0;

    always #10 clk = ~clk;

    i2c_tx_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_data     (wr_data),
        .data_in     (data_in),
        .full        (full),
        .almost_full (almost_full),
        .read        (read),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .empty_tx    (empty_tx),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model
    task automatic check_all();
        chk("count",       32'(count),       32'(q.size()));
        chk("empty_tx",    32'(empty_tx),    32'(q.size() == 0));
        chk("full",        32'(full),        32'(q.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
        chk("data_out",    32'(data_out),    32'(m_dout));
        chk("rd_valid",    32'(rd_valid),    32'(m_valid));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("underflow",   32'(underflow),   32'(m_udf));
    endtask

    // Apply one cycle of stimulus, update the model, check after the edge
    task automatic step(input logic wr, input logic [DATA_W-1:0] din,
                        input logic rd, input logic clr);
        bit wr_ok;
        bit rd_ok;
        wr_data = wr;
        data_in = din;
        read    = rd;
        clr_err = clr;
        wr_ok   = wr && (q.size() < DEPTH);
        rd_ok   = rd && (q.size() > 0);
        m_valid = 1'b0;
        if (rd_ok) begin
            m_dout  = q.pop_front();
            m_valid = 1'b1;
        end
        if (wr_ok) q.push_back(din);
        if (wr && !wr_ok) m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        if (rd && !rd_ok) m_udf = 1'b1;
        else if (clr)     m_udf = 1'b0;
        @(posedge clk);
        #1;
        wr_data = 1'b0;
        read    = 1'b0;
        clr_err = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_all();
        release_reset();
        step(0, 8'h00, 0, 0);

        // Two bytes in, two out
        step(1, 8'hA5, 0, 0);
        step(1, 8'h3C, 0, 0);
        step(0, 8'h00, 1, 0);
        chk("first_byte", 32'(data_out), 32'hA5);
        step(0, 8'h00, 1, 0);
        chk("second_byte", 32'(data_out), 32'h3C);
        step(0, 8'h00, 0, 0);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(i), 0, 0);
            if (i == AF_LEVEL - 2) chk("af_before", 32'(almost_full), 32'd0);
            if (i == AF_LEVEL - 1) chk("af_rise",   32'(almost_full), 32'd1);
        end
        chk("full_at_16", 32'(full), 32'd1);
        step(1, 8'hFF, 0, 0);
        chk("count_after_ovf", 32'(count), 32'd16);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 8'h00, 1, 0);
            chk("drain_order", 32'(data_out), 32'(i));
        end

        // Underflow and clear
        step(0, 8'h00, 1, 0);
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_no_valid", 32'(rd_valid), 32'd0);
        chk("udf_dout_hold", 32'(data_out), 32'h0F);
        step(0, 8'h00, 0, 1);
        chk("udf_cleared", 32'(underflow), 32'd0);

        // Simultaneous write+read on empty: write only, underflow set
        step(1, 8'h5A, 1, 0);
        step(0, 8'h00, 1, 1);
        chk("no_bypass_byte", 32'(data_out), 32'h5A);

        // Pointer wrap with single-entry ping-pong
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h40 + i), 0, 0);
            chk("wrap_count1", 32'(count), 32'd1);
            step(0, 8'h00, 1, 0);
            chk("wrap_byte", 32'(data_out), 32'(8'h40 + i));
        end

        // Simultaneous at count=5
        for (int i = 0; i < 5; i++) step(1, 8'(8'h90 + i), 0, 0);
        step(1, 8'h77, 1, 0);
        chk("sim5_count", 32'(count), 32'd5);
        chk("sim5_oldest", 32'(data_out), 32'h90);

        // Simultaneous at count=16
        while (q.size() < DEPTH) step(1, 8'($urandom), 0, 0);
        step(1, 8'hEE, 1, 0);
        chk("sim16_count", 32'(count), 32'd15);
        chk("sim16_ovf", 32'(overflow), 32'd1);
        step(0, 8'h00, 0, 1);

        // Asynchronous reset mid-cycle, right after a read pulse
        step(0, 8'h00, 1, 0);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async_count", 32'(count), 32'd0);
        chk("async_empty", 32'(empty_tx), 32'd1);
        chk("async_valid", 32'(rd_valid), 32'd0);
        chk("async_dout", 32'(data_out), 32'd0);
        check_all();
        release_reset();
        check_all();

        // Random traffic: fill-biased phase then drain-biased phase
        for (int i = 0; i < 600; i++) begin
            bit wr_r;
            bit rd_r;
            if (i < 300) begin
                wr_r = ($urandom % 4) != 0;
                rd_r = ($urandom % 4) == 0;
            end else begin
                wr_r = ($urandom % 4) == 0;
                rd_r = ($urandom % 4) != 0;
            end
            step(wr_r, 8'($urandom), rd_r, ($urandom % 16) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
